// File: rtl/multicycle_controller.sv
// Multicycle instruction-sequencing controller: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, drives datapath strobes and counts retirements.
module multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      inst,
    input  logic             BrEq,
    input  logic             BrLt,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             addr_sel,
    output logic             MemRW,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWEn,
    output logic             PCSel,
    output logic             BrUn,
    output logic [2:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    // state  | meaning
    // FETCH  | read instruction at PC, wait for mem_ready, load IR
    // DECODE | classify opcode, trap on anything unsupported
    // EXEC   | ALU step; branches resolve and retire here
    // MEM    | data access at ALU address; stores retire here
    // WB     | register write-back and PC update, one cycle
    // TRAP   | illegal instruction seen, parked until reset
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic [4:0] opc;
    logic [2:0] funct3;
    logic       is_r, is_i, is_load, is_store, is_br, is_jal, is_jalr;
    logic       br_ok, legal, taken;
    logic       unused_inst;

    assign opc    = inst[6:2];
    assign funct3 = inst[14:12];

    assign is_r     = (opc == 5'b01100);
    assign is_i     = (opc == 5'b00100);
    assign is_load  = (opc == 5'b00000);
    assign is_store = (opc == 5'b01000);
    assign is_br    = (opc == 5'b11000);
    assign is_jal   = (opc == 5'b11011);
    assign is_jalr  = (opc == 5'b11001);

    // funct3 010/011 have no branch encoding
    assign br_ok = (funct3[2:1] != 2'b01);

    assign legal = (inst[1:0] == 2'b11) &&
                   (is_r || is_i || is_load || is_store || is_jal || is_jalr ||
                    (is_br && br_ok));

    assign unused_inst = ^{inst[31:15], inst[11:7]};

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:         taken = BrEq;
            3'b001:         taken = ~BrEq;
            3'b100, 3'b110: taken = BrLt;
            3'b101, 3'b111: taken = ~BrLt;
            default:        taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        mem_req  = 1'b0;
        addr_sel = 1'b0;
        MemRW    = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        RegWEn   = 1'b0;
        PCSel    = 1'b0;
        BrUn     = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                if (is_r || is_i || is_jal || is_jalr) begin
                    state_d = S_WB;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else if (is_br) begin
                    BrUn    = inst[13];
                    PCWrite = 1'b1;
                    PCSel   = taken;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_TRAP;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                MemRW    = is_store;
                if (mem_ready) begin
                    if (is_store) begin
                        PCWrite = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                RegWEn  = 1'b1;
                PCWrite = 1'b1;
                PCSel   = is_jal || is_jalr;
                state_d = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase

        // Reset cycles must not start accesses or commit anything
        if (rst) begin
            mem_req  = 1'b0;
            addr_sel = 1'b0;
            MemRW    = 1'b0;
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            RegWEn   = 1'b0;
            PCSel    = 1'b0;
            BrUn     = 1'b0;
        end
    end

    assign illegal_d = illegal_q || (state_d == S_TRAP);
    assign instret_d = instret_q + CNT_W'(PCWrite);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            instret_q <= instret_d;
        end
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign instret = instret_q;

endmodule
